func_eval_seq: RTL and testbench
================================

# func_eval_seq

Sequenced rational-function evaluator for the complex-plane datapath. It accepts one complex sample z per handshake and computes a numerator and a denominator over a configurable table of roots: num = Π(z − zero_k) and den = Π(z − pole_k). A single shared complex multiplier is time-multiplexed across all factors, one factor per cycle. It sits between the pixel-coordinate generator and the downstream complex divider/colour mapper, and replaces fixed, fully combinational root products.

## Interface
- N_ROOTS, 4: maximum zeros and maximum poles, each stored in its own table.
- W, 16: word width of every real/imaginary value; signed two's complement.
- FRAC, 8: fractional bits (Q8.8 at defaults); 1.0 = 0x0100.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  root-table write strobe.
- cfg_sel  in  1  0 = zero table, 1 = pole table.
- cfg_idx  in  clog2(N_ROOTS)  table entry.
- cfg_re, cfg_im  in  W  root value.
- n_zeros, n_poles  in  clog2(N_ROOTS)+1  active factor counts; sampled on accept.
- in_valid  in  1  z presented.
- in_ready  out  1  block idle, can accept.
- z_re, z_im  in  W  sample.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts result.
- num_re, num_im, den_re, den_im  out  W  result.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, ZMUL, PMUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch z, nz=min(n_zeros,N_ROOTS), np=min(n_poles,N_ROOTS), set acc=1.0+0j and k=0. Next state: ZMUL if nz>0, else PMUL if np>0, else DONE.
- ZMUL: each cycle computes acc ← acc·(z − zero[k]) and k++. After the factor k=nz−1, copy acc to num, reset acc=1.0 and k=0. Next state: PMUL if np>0, else DONE.
- PMUL: same operation over pole[k]. After the factor k=np−1, copy acc to den and go to DONE.
- Empty product: when nz=0, num=1.0+0j (0x0100, 0x0000). The same rule applies to den when np=0.
- DONE: out_valid=1 and outputs stay stable. On out_ready, go to IDLE.
- Subtraction is W-bit with wrap-around. There is no saturation.
- Multiply: form the 2W+1-bit products re=ar·br−ai·bi and im=ar·bi+ai·br. Arithmetic-shift each right by FRAC (floor), then keep the low W bits (wrap).
- There is exactly one multiplier instance. The subtractor feeding it is combinational on the latched z and the table entry.
- cfg_we is honoured only in IDLE. Writes in any other state are dropped, so the table stays constant during an evaluation.
- in_valid is ignored outside IDLE.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0. num_* = den_* = 0. All table entries are 0+0j.
- Accept at edge E. out_valid rises at edge E+nz+np+1 (DONE entered), or E+1 when nz=np=0.
- Throughput: one sample per nz+np+2 cycles when out_ready is held high. The DONE→IDLE cycle is not overlapped with the next accept.
- A cfg write in IDLE takes effect at the next edge. A write and an accept in the same cycle: the write lands, but the evaluation sampled at that edge uses the old entry.
- out_ready low in DONE: hold all outputs indefinitely. in_ready stays 0.
- rst asserted mid-evaluation: immediately force reset values. The next accept starts cleanly.

## Test plan
- zeros={1+1j, 0}, z=0x0200+0x0100j, n_zeros=2, n_poles=0 -> num=0x0200/0x0100, den=0x0100/0x0000; out_valid 3 cycles after accept.
- pole[0]=0xFF00+0j (−1), zeros as above, z=0+0x0100j, n_zeros=2, n_poles=1 -> den=0x0100/0x0100; out_valid exactly 4 cycles after accept.
- zeros all 0, z=0x7F00+0j, n_zeros=2 -> num_re wraps to 0x0100, num_im=0x0000.
- n_zeros=0, n_poles=0 -> num=den=0x0100/0x0000 one cycle after accept. n_zeros=7 is clamped to 4 factors.
- Backpressure and ignored writes: out_ready=0 for 10 cycles -> outputs stable, in_ready=0, new in_valid ignored. A cfg_we during ZMUL leaves the table unchanged, verified by re-evaluation.
- rst pulse during PMUL -> out_valid=0, outputs 0, table cleared. A following sample with n_zeros=1 gives num=z.

Source files
------------

// File: rtl/func_eval_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | func_eval_seq_if : root-table config, sample and result handshake bundle   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface func_eval_seq_if #(
  parameter int N_ROOTS = 4,
  parameter int W       = 16
);
  localparam int c_iw = (N_ROOTS > 1) ? $clog2(N_ROOTS) : 1;
  localparam int c_cw = $clog2(N_ROOTS) + 1;

  logic            cfg_we;
  logic            cfg_sel;
  logic [c_iw-1:0] cfg_idx;
  logic [W-1:0]    cfg_re;
  logic [W-1:0]    cfg_im;
  logic [c_cw-1:0] n_zeros;
  logic [c_cw-1:0] n_poles;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    z_re;
  logic [W-1:0]    z_im;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    num_re;
  logic [W-1:0]    num_im;
  logic [W-1:0]    den_re;
  logic [W-1:0]    den_im;
  logic            busy;

  modport master (
    output cfg_we, cfg_sel, cfg_idx, cfg_re, cfg_im,
    output n_zeros, n_poles, in_valid, z_re, z_im, out_ready,
    input  in_ready, out_valid, num_re, num_im, den_re, den_im, busy
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_idx, cfg_re, cfg_im,
    input  n_zeros, n_poles, in_valid, z_re, z_im, out_ready,
    output in_ready, out_valid, num_re, num_im, den_re, den_im, busy
  );
endinterface
`default_nettype wire

// File: rtl/func_eval_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | func_eval_seq : sequenced num = prod(z - zero_k), den = prod(z - pole_k)   |
// | with one shared complex multiplier, one factor per cycle.  Rev 1.0         |
// +----------------------------------------------------------------------------+
module func_eval_seq #(
  parameter int N_ROOTS = 4,
  parameter int W       = 16,
  parameter int FRAC    = 8
) (
  input wire            clk,
  input wire            rst,
  func_eval_seq_if.slave bus
);
  localparam int              c_iw  = (N_ROOTS > 1) ? $clog2(N_ROOTS) : 1;
  localparam int              c_cw  = $clog2(N_ROOTS) + 1;
  localparam logic [W-1:0]    c_one = W'(1) << FRAC;
  localparam logic [c_cw-1:0] c_max = c_cw'(N_ROOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZMUL = 2'd1,
    PMUL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0] r_zero_re [N_ROOTS];
  logic [W-1:0] r_zero_im [N_ROOTS];
  logic [W-1:0] r_pole_re [N_ROOTS];
  logic [W-1:0] r_pole_im [N_ROOTS];

  logic [W-1:0]    r_z_re, r_z_im;
  logic [W-1:0]    r_acc_re, r_acc_im;
  logic [W-1:0]    r_num_re, r_num_im, r_den_re, r_den_im;
  logic [c_cw-1:0] r_nz, r_np;
  logic [c_iw-1:0] r_k;

  // Entry overwritten in the accept cycle; the evaluation keeps seeing its old value.
  logic            r_sh_vld;
  logic            r_sh_sel;
  logic [c_iw-1:0] r_sh_idx;
  logic [W-1:0]    r_sh_re, r_sh_im;

  logic            w_accept;
  logic            w_cfg_ok;
  logic [c_cw-1:0] w_nz, w_np, w_cnt;
  logic            w_last;
  logic [W-1:0]    w_old_re, w_old_im;
  logic [W-1:0]    w_root_re, w_root_im;
  logic [W-1:0]    w_d_re, w_d_im;
  logic [W-1:0]    w_mul_re, w_mul_im;

  logic signed [2*W-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [2*W:0]   w_s_re, w_s_im;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_cfg_ok = (r_state == IDLE) && bus.cfg_we && (int'(bus.cfg_idx) < N_ROOTS);
  assign w_nz     = (bus.n_zeros > c_max) ? c_max : bus.n_zeros;
  assign w_np     = (bus.n_poles > c_max) ? c_max : bus.n_poles;
  assign w_cnt    = (r_state == PMUL) ? r_np : r_nz;
  assign w_last   = ((c_cw'(r_k) + c_cw'(1)) == w_cnt);

  assign w_old_re = bus.cfg_sel ? r_pole_re[bus.cfg_idx] : r_zero_re[bus.cfg_idx];
  assign w_old_im = bus.cfg_sel ? r_pole_im[bus.cfg_idx] : r_zero_im[bus.cfg_idx];

  always_comb begin
    w_root_re = r_zero_re[r_k];
    w_root_im = r_zero_im[r_k];
    if (r_state == PMUL) begin
      w_root_re = r_pole_re[r_k];
      w_root_im = r_pole_im[r_k];
    end
    if (r_sh_vld && (r_sh_sel == (r_state == PMUL)) && (r_sh_idx == r_k)) begin
      w_root_re = r_sh_re;
      w_root_im = r_sh_im;
    end
  end

  assign w_d_re = r_z_re - w_root_re;
  assign w_d_im = r_z_im - w_root_im;

  // The single complex multiplier; floor shift by FRAC then wrap to W bits.
  assign w_p_rr = $signed(r_acc_re) * $signed(w_d_re);
  assign w_p_ii = $signed(r_acc_im) * $signed(w_d_im);
  assign w_p_ri = $signed(r_acc_re) * $signed(w_d_im);
  assign w_p_ir = $signed(r_acc_im) * $signed(w_d_re);

  assign w_s_re = $signed({w_p_rr[2*W-1], w_p_rr}) - $signed({w_p_ii[2*W-1], w_p_ii});
  assign w_s_im = $signed({w_p_ri[2*W-1], w_p_ri}) + $signed({w_p_ir[2*W-1], w_p_ir});

  assign w_mul_re = w_s_re[FRAC +: W];
  assign w_mul_im = w_s_im[FRAC +: W];

  logic w_unused_bits;
  assign w_unused_bits = ^{w_s_re[FRAC-1:0], w_s_re[2*W:FRAC+W],
                           w_s_im[FRAC-1:0], w_s_im[2*W:FRAC+W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          if (w_nz != '0)      w_next = ZMUL;
          else if (w_np != '0) w_next = PMUL;
          else                 w_next = DONE;
        end
      end
      ZMUL: begin
        if (w_last) w_next = (r_np != '0) ? PMUL : DONE;
      end
      PMUL: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ROOTS; i++) begin
        r_zero_re[i] <= '0;
        r_zero_im[i] <= '0;
        r_pole_re[i] <= '0;
        r_pole_im[i] <= '0;
      end
      r_z_re   <= '0;
      r_z_im   <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_num_re <= '0;
      r_num_im <= '0;
      r_den_re <= '0;
      r_den_im <= '0;
      r_nz     <= '0;
      r_np     <= '0;
      r_k      <= '0;
      r_sh_vld <= 1'b0;
      r_sh_sel <= 1'b0;
      r_sh_idx <= '0;
      r_sh_re  <= '0;
      r_sh_im  <= '0;
    end else begin
      if (w_cfg_ok) begin
        if (bus.cfg_sel) begin
          r_pole_re[bus.cfg_idx] <= bus.cfg_re;
          r_pole_im[bus.cfg_idx] <= bus.cfg_im;
        end else begin
          r_zero_re[bus.cfg_idx] <= bus.cfg_re;
          r_zero_im[bus.cfg_idx] <= bus.cfg_im;
        end
      end
      if (w_accept) begin
        r_z_re   <= bus.z_re;
        r_z_im   <= bus.z_im;
        r_nz     <= w_nz;
        r_np     <= w_np;
        r_k      <= '0;
        r_acc_re <= c_one;
        r_acc_im <= '0;
        // Empty products stay at 1.0; non-empty ones are overwritten at their last factor.
        r_num_re <= c_one;
        r_num_im <= '0;
        r_den_re <= c_one;
        r_den_im <= '0;
        r_sh_vld <= w_cfg_ok;
        r_sh_sel <= bus.cfg_sel;
        r_sh_idx <= bus.cfg_idx;
        r_sh_re  <= w_old_re;
        r_sh_im  <= w_old_im;
      end
      if ((r_state == ZMUL) || (r_state == PMUL)) begin
        if (w_last) begin
          r_acc_re <= c_one;
          r_acc_im <= '0;
          r_k      <= '0;
          if (r_state == ZMUL) begin
            r_num_re <= w_mul_re;
            r_num_im <= w_mul_im;
          end else begin
            r_den_re <= w_mul_re;
            r_den_im <= w_mul_im;
          end
        end else begin
          r_acc_re <= w_mul_re;
          r_acc_im <= w_mul_im;
          r_k      <= r_k + c_iw'(1);
        end
      end
    end
  end

  assign bus.num_re = r_num_re;
  assign bus.num_im = r_num_im;
  assign bus.den_re = r_den_re;
  assign bus.den_im = r_den_im;
endmodule
`default_nettype wire

// File: tb/tb_func_eval_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_func_eval_seq : directed + randomized bench with a behavioural model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_func_eval_seq;
  localparam int c_n    = 4;
  localparam int c_w    = 16;
  localparam int c_frac = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  func_eval_seq_if #(.N_ROOTS(c_n), .W(c_w)) bus ();

  func_eval_seq #(.N_ROOTS(c_n), .W(c_w), .FRAC(c_frac)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [15:0] zt_re [c_n];
  logic [15:0] zt_im [c_n];
  logic [15:0] pt_re [c_n];
  logic [15:0] pt_im [c_n];
  logic [15:0] e_nr, e_ni, e_dr, e_di;
  int          e_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Complex product in plain integer arithmetic, floor-scaled and wrapped to 16 bits.
  task automatic cmul(inout longint ar, inout longint ai, input longint br, input longint bi);
    longint pr, pi;
    pr = ar * br - ai * bi;
    pi = ar * bi + ai * br;
    ar = sx(16'(pr >>> c_frac));
    ai = sx(16'(pi >>> c_frac));
  endtask

  task automatic model(input logic [15:0] zr, input logic [15:0] zi, input int nzi, input int npi);
    longint      ar, ai;
    int          nz, np;
    logic [15:0] dr, di;
    nz = (nzi > c_n) ? c_n : nzi;
    np = (npi > c_n) ? c_n : npi;
    ar = 256; ai = 0;
    for (int k = 0; k < nz; k++) begin
      dr = zr - zt_re[k]; di = zi - zt_im[k];
      cmul(ar, ai, sx(dr), sx(di));
    end
    e_nr = 16'(ar); e_ni = 16'(ai);
    ar = 256; ai = 0;
    for (int k = 0; k < np; k++) begin
      dr = zr - pt_re[k]; di = zi - pt_im[k];
      cmul(ar, ai, sx(dr), sx(di));
    end
    e_dr = 16'(ar); e_di = 16'(ai);
    e_lat = nz + np + 1;
  endtask

  task automatic cfg(input bit sel, input int idx, input logic [15:0] re, input logic [15:0] im);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_idx = 2'(idx);
    bus.cfg_re = re;   bus.cfg_im = im;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (sel) begin pt_re[idx] = re; pt_im[idx] = im; end
    else     begin zt_re[idx] = re; zt_im[idx] = im; end
  endtask

  task automatic start(input logic [15:0] zr, input logic [15:0] zi, input int nzi, input int npi);
    model(zr, zi, nzi, npi);
    bus.z_re = zr; bus.z_im = zi;
    bus.n_zeros = 3'(nzi); bus.n_poles = 3'(npi);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int already);
    int cyc;
    cyc = already;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(e_lat));
    chk({tag, " num"}, {bus.num_re, bus.num_im}, {e_nr, e_ni});
    chk({tag, " den"}, {bus.den_re, bus.den_im}, {e_dr, e_di});
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " back to idle"}, {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] zr, zi;
    int          nzi, npi;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_idx = '0;
    bus.cfg_re = '0;   bus.cfg_im = '0;
    bus.n_zeros = '0;  bus.n_poles = '0;
    bus.in_valid = 1'b0; bus.z_re = '0; bus.z_im = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < c_n; i++) begin
      zt_re[i] = '0; zt_im[i] = '0; pt_re[i] = '0; pt_im[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("reset flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk("reset num", {bus.num_re, bus.num_im}, 32'h0);
    chk("reset den", {bus.den_re, bus.den_im}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two zeros, no poles
    cfg(1'b0, 0, 16'h0100, 16'h0100);
    cfg(1'b0, 1, 16'h0000, 16'h0000);
    start(16'h0200, 16'h0100, 2, 0);
    wait_done("t1", 1);
    chk("t1 num const", {bus.num_re, bus.num_im}, 32'h0200_0100);
    chk("t1 den const", {bus.den_re, bus.den_im}, 32'h0100_0000);
    release_out("t1");

    // One pole at -1
    cfg(1'b1, 0, 16'hFF00, 16'h0000);
    start(16'h0000, 16'h0100, 2, 1);
    wait_done("t2", 1);
    chk("t2 den const", {bus.den_re, bus.den_im}, 32'h0100_0100);
    release_out("t2");

    // Wrap-around of the product
    cfg(1'b0, 0, 16'h0000, 16'h0000);
    start(16'h7F00, 16'h0000, 2, 0);
    wait_done("t3", 1);
    chk("t3 num const", {bus.num_re, bus.num_im}, 32'h0100_0000);
    release_out("t3");

    // Empty products
    start(16'($urandom), 16'($urandom), 0, 0);
    wait_done("t4", 1);
    chk("t4 consts", {bus.num_re, bus.num_im, bus.den_re, bus.den_im}, 64'h0100_0000_0100_0000);
    release_out("t4");

    // Clamp n_zeros=7 to the table size
    for (int i = 0; i < c_n; i++) cfg(1'b0, i, 16'($urandom), 16'($urandom));
    start(16'($urandom), 16'($urandom), 7, 0);
    wait_done("t5 clamp", 1);
    release_out("t5");

    // Randomized tables, samples and counts
    for (int it = 0; it < 12; it++) begin
      cfg(1'($urandom), int'($urandom_range(0, c_n - 1)), 16'($urandom), 16'($urandom));
      cfg(1'($urandom), int'($urandom_range(0, c_n - 1)), 16'($urandom), 16'($urandom));
      start(16'($urandom), 16'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      wait_done("rand", 1);
      release_out("rand");
    end

    // Backpressure: outputs hold and new samples are ignored
    bus.out_ready = 1'b0;
    start(16'($urandom), 16'($urandom), 3, 2);
    wait_done("bp", 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.z_re = 16'($urandom); bus.n_zeros = 3'd1;
      @(posedge clk); #1;
      chk("bp hold", {bus.out_valid, bus.in_ready, bus.num_re, bus.num_im, bus.den_re, bus.den_im},
          {1'b1, 1'b0, e_nr, e_ni, e_dr, e_di});
    end
    bus.in_valid = 1'b0;
    release_out("bp");

    // Config writes while busy are dropped
    zr = 16'($urandom); zi = 16'($urandom);
    start(zr, zi, 4, 4);
    for (int i = 0; i < 3; i++) begin
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'(i); bus.cfg_idx = 2'(i + 1);
      bus.cfg_re = 16'($urandom); bus.cfg_im = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.cfg_we = 1'b0;
    wait_done("busy write", 4);
    release_out("busy write");
    start(zr, zi, 4, 4);
    wait_done("re-eval", 1);
    release_out("re-eval");

    // Write and accept in the same cycle: evaluation uses the old entry
    zr = 16'($urandom); zi = 16'($urandom);
    model(zr, zi, 2, 1);
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_idx = 2'd0;
    bus.cfg_re = 16'($urandom); bus.cfg_im = 16'($urandom);
    bus.z_re = zr; bus.z_im = zi; bus.n_zeros = 3'd2; bus.n_poles = 3'd1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
    zt_re[0] = bus.cfg_re; zt_im[0] = bus.cfg_im;
    wait_done("same-cycle old", 1);
    release_out("same-cycle");
    start(zr, zi, 2, 1);
    wait_done("same-cycle new", 1);
    release_out("same-cycle new");

    // Reset in the middle of the pole phase
    start(16'($urandom), 16'($urandom), 1, 4);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk("midrst outs", {bus.num_re, bus.num_im, bus.den_re, bus.den_im}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < c_n; i++) begin
      zt_re[i] = '0; zt_im[i] = '0; pt_re[i] = '0; pt_im[i] = '0;
    end
    zr = 16'($urandom); zi = 16'($urandom);
    nzi = 1; npi = 1;
    start(zr, zi, nzi, npi);
    wait_done("post-rst", 1);
    chk("post-rst num=z", {bus.num_re, bus.num_im}, {zr, zi});
    chk("post-rst den=z", {bus.den_re, bus.den_im}, {zr, zi});
    release_out("post-rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
